array_structural: RTL and testbench

- 4-word x WIDTH-bit register-file memory built structurally.
- Consists of a 2-to-4 write-address decoder, four independently enabled word registers, and a 4:1 combinational read multiplexer.
- Provides one synchronous write port and one asynchronous (combinational) read port.
- Used as a small scratch storage array; the structural decomposition makes per-word write enables explicit.

---
 rtl/array_structural.sv | 114 +++++++++++
 tb/tb_array_structural.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/array_structural.sv
// array_structural: 4-word x WIDTH-bit register file built from a write
// decoder, four enabled word registers and a combinational 4:1 read mux.
// One synchronous write port, one asynchronous read port.

// Single word register with synchronous active-high clear and load enable.
module array_structural_wreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear on reset (reset beats a simultaneous load), otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// 2-to-4 write-address decoder gated by the global write enable.
module array_structural_dec2to4 (
    input  logic       i_en,
    input  logic [1:0] i_addr,
    output logic [3:0] o_sel
);

    // One-hot select when enabled, all zero otherwise.
    always_comb begin
        o_sel = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            o_sel[k] = i_en && (i_addr == k[1:0]);
        end
    end

endmodule

// 4:1 combinational read multiplexer.
module array_structural_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_y
);

    // Route the selected word straight to the output, no clocking.
    always_comb begin
        o_y = '0;
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end

endmodule

// Top level: decoder -> four word registers -> read mux.
module array_structural #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] write_data,
    input  logic [1:0]       write_addr,
    input  logic             write_en,
    input  logic [1:0]       read_addr,
    output logic [WIDTH-1:0] read_data
);

    logic [3:0]       w_we;
    logic [WIDTH-1:0] w_word [4];

    array_structural_dec2to4 u_dec (
        .i_en   (write_en),
        .i_addr (write_addr),
        .o_sel  (w_we)
    );

    for (genvar g = 0; g < 4; g++) begin : g_word
        array_structural_wreg #(.WIDTH(WIDTH)) u_word (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_we[g]),
            .i_d  (write_data),
            .o_q  (w_word[g])
        );
    end

    array_structural_mux4 #(.WIDTH(WIDTH)) u_mux (
        .i_d0  (w_word[0]),
        .i_d1  (w_word[1]),
        .i_d2  (w_word[2]),
        .i_d3  (w_word[3]),
        .i_sel (read_addr),
        .o_y   (read_data)
    );

endmodule

// File: tb/tb_array_structural.sv
// Self-checking bench for array_structural: directed vector table,
// a hand-written reset-mid-sequence case, and randomized traffic
// checked against a plain array model of the four words.
module tb_array_structural;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] write_data;
    logic [1:0]       write_addr;
    logic             write_en;
    logic [1:0]       read_addr;
    logic [WIDTH-1:0] read_data;

    int n_tests;
    int n_fail;

    logic [WIDTH-1:0] mdl [4];

    typedef struct {
        logic             rst;
        logic             we;
        logic [1:0]       wa;
        logic [WIDTH-1:0] wd;
        logic [1:0]       ra;
        logic             chk_pre;
        logic [WIDTH-1:0] pre;
        logic [WIDTH-1:0] post;
    } vec_t;

    vec_t vt[$];

    array_structural #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_data (write_data),
        .write_addr (write_addr),
        .write_en   (write_en),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: read_data=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic we, input logic [1:0] wa,
                       input logic [WIDTH-1:0] wd, input logic [1:0] ra,
                       input logic cp, input logic [WIDTH-1:0] pre,
                       input logic [WIDTH-1:0] post);
        vec_t v;
        v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
        v.chk_pre = cp; v.pre = pre; v.post = post;
        vt.push_back(v);
    endtask

    // One clock cycle driven from the negedge, checked against the model
    // before the edge, after a mid-cycle read_addr change, and after the edge.
    task automatic step(input string name, input logic r, input logic we,
                        input logic [1:0] wa, input logic [WIDTH-1:0] wd,
                        input logic [1:0] ra, input logic [1:0] ra2);
        rst = r; write_en = we; write_addr = wa; write_data = wd; read_addr = ra;
        #1;
        check({name, "_pre"}, read_data, mdl[ra]);
        read_addr = ra2;
        #1;
        check({name, "_raddr_change"}, read_data, mdl[ra2]);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) mdl[i] = '0;
        end else if (we) begin
            mdl[wa] = wd;
        end
        #1;
        check({name, "_post"}, read_data, mdl[ra2]);
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; write_en = 1'b0; write_addr = '0; write_data = '0; read_addr = '0;

        //   rst we  wa  wd     ra  cp  pre    post
        add(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        add(0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00);
        add(0, 0, 0, 8'h00, 2, 1, 8'h00, 8'h00);
        add(0, 0, 0, 8'h00, 3, 1, 8'h00, 8'h00);
        add(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h00);
        add(0, 1, 1, 8'h33, 1, 1, 8'h00, 8'h33);
        add(0, 1, 2, 8'h66, 2, 1, 8'h00, 8'h66);
        add(0, 1, 3, 8'h99, 3, 1, 8'h00, 8'h99);
        add(0, 0, 1, 8'hFF, 0, 1, 8'h00, 8'h00);
        add(0, 0, 1, 8'hFF, 1, 1, 8'h33, 8'h33);
        add(0, 0, 1, 8'hFF, 2, 1, 8'h66, 8'h66);
        add(0, 0, 1, 8'hFF, 3, 1, 8'h99, 8'h99);
        add(0, 0, 1, 8'hFF, 1, 1, 8'h33, 8'h33);
        add(0, 1, 2, 8'hA5, 2, 1, 8'h66, 8'hA5);
        add(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00);
        add(0, 0, 0, 8'h00, 1, 1, 8'h33, 8'h33);
        add(0, 0, 0, 8'h00, 3, 1, 8'h99, 8'h99);
        add(0, 1, 3, 8'h5A, 3, 1, 8'h99, 8'h5A);
        add(1, 1, 1, 8'h77, 1, 1, 8'h33, 8'h00);
        add(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00);
        add(0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00);
        add(0, 0, 0, 8'h00, 2, 1, 8'h00, 8'h00);
        add(0, 0, 0, 8'h00, 3, 1, 8'h00, 8'h00);

        @(negedge clk);
        foreach (vt[i]) begin
            rst = vt[i].rst; write_en = vt[i].we; write_addr = vt[i].wa;
            write_data = vt[i].wd; read_addr = vt[i].ra;
            #1;
            if (vt[i].chk_pre) check($sformatf("vec%0d_pre", i), read_data, vt[i].pre);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_post", i), read_data, vt[i].post);
            @(negedge clk);
        end

        // Table ends after a reset with no writes: every word is zero.
        for (int i = 0; i < 4; i++) mdl[i] = '0;

        // Back-to-back writes to all words, then reset clears them all.
        step("fill0", 0, 1, 0, 8'hC1, 0, 3);
        step("fill1", 0, 1, 1, 8'h3C, 1, 0);
        step("fill2", 0, 1, 2, 8'hFE, 2, 1);
        step("fill3", 0, 1, 3, 8'h81, 3, 2);
        step("midrst", 1, 1, 2, 8'h55, 2, 0);
        step("after_rst1", 0, 0, 0, 8'h00, 1, 2);
        step("after_rst2", 0, 0, 0, 8'h00, 3, 3);

        // Randomized traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            step($sformatf("rand%0d", n),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 WIDTH'($urandom),
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
